imem_loader: RTL and testbench
==============================

# imem_loader

Parametrised, synchronous instruction memory for the RISC-V core with a built-in byte-stream program loader. A loader FSM assembles incoming bytes into little-endian words and writes them sequentially from word 0. The fetch port returns a registered instruction one cycle after a fetch request. Unloaded, misaligned or out-of-range fetches return a fixed default instruction instead of an undefined value.

## Interface
- N, 32, instruction and address width in bits.
- DEPTH, 64, number of instruction words; legal byte addresses are 0 .. 4*DEPTH-4.
- DEFAULT_INSTR, 32'h00000013, word returned for unloaded, misaligned or out-of-range fetches (NOP, addi x0,x0,0).

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- pc_out  in  N  fetch byte address.
- fetch_en  in  1  fetch request; pc_out is sampled on the same edge.
- instr  out  N  registered fetched instruction.
- instr_valid  out  1  instr holds the result of a fetch accepted on the previous edge.
- fault  out  1  qualified by instr_valid; the accepted address was misaligned or out of range.
- ld_start  in  1  single-cycle pulse; starts or restarts a load.
- ld_valid  in  1  ld_data is valid.
- ld_data  in  8  program byte.
- ld_last  in  1  qualified by ld_valid; marks the final byte of the program.
- ld_ready  out  1  loader accepts a byte.
- busy  out  1  a load is in progress.
- ld_words  out  $clog2(DEPTH)+1  count of words committed since the last ld_start.
- ld_overflow  out  1  sticky; a byte arrived after DEPTH words were committed.

## Operation
- **FSM states:** IDLE and LOAD.
  - IDLE: ld_ready=0, busy=0.
  - LOAD: ld_ready=1, busy=1.
- **ld_start, any state:**
  - Next state is LOAD.
  - Clears the byte counter, the word pointer, ld_words and ld_overflow.
  - A byte presented in the same cycle is ignored.
- **Byte acceptance:** a byte is accepted when ld_valid && ld_ready.
  - Byte k (k = 0..3) is placed in the assembly register at bits [8k+7:8k].
- **Word commit:** occurs on the 4th accepted byte, or on any accepted byte with ld_last=1.
  - The assembled word is written to mem[wptr], with unfilled upper bytes set to zero.
  - Then wptr++, ld_words++, and the byte counter returns to 0.
- **End of load:** ld_last on an accepted byte commits as above, then the FSM goes to IDLE.
- **Overflow:** a byte accepted while wptr==DEPTH is dropped and sets ld_overflow.
  - ld_ready stays 1 so the source drains.
  - ld_last still returns the FSM to IDLE.
- **Fetch:** accepted when fetch_en=1 and busy=0. When busy=1, fetch_en is ignored and instr_valid=0 on the next cycle.
- **Fetch result for accepted address A** (word index W = A[N-1:2]):
  - A[1:0]!=0 or W>=DEPTH: instr=DEFAULT_INSTR, fault=1.
  - W>=ld_words (word not loaded): instr=DEFAULT_INSTR, fault=0.
  - Otherwise: instr=mem[W], fault=0.
- **Memory contents:** undefined after reset. The ld_words gating guarantees an unloaded word is never returned.
- **Holding:** when no fetch is accepted, instr holds its last value, fault holds, and instr_valid=0.

## Timing
- **Reset values:**
  - instr=DEFAULT_INSTR, instr_valid=0, fault=0.
  - ld_ready=0, busy=0, ld_words=0, ld_overflow=0.
  - FSM in IDLE; byte counter and wptr are 0.
- **Reset mid-load:** discards the partial word. Words already committed are treated as unloaded because ld_words=0.
- **Fetch latency:** 1 cycle from the accepting edge to instr/instr_valid/fault.
- **Back-to-back fetches:** a new fetch can be accepted every cycle.
- **Loader rate:** one byte per cycle.
- **Commit visibility:**
  - The mem write and the ld_words increment take effect on the same edge.
  - A fetch of that word is only possible after busy falls.
- **busy after ld_start:** rises the cycle after the ld_start edge.
- **busy after final byte:** falls the cycle after the edge accepting the ld_last byte.
- **Fetch/load collisions:** no read/write collision is possible, because fetches are blocked while busy.

## Test plan
- **Reset:** hold rst_n=0, then release. Required: all outputs at reset values. Fetch A=0 returns instr=32'h00000013, fault=0.
- **Full-word load:**
  - Stimulus: ld_start, then stream bytes 13 07 20 00 13 04 A0 00, with ld_last on the 8th byte.
  - Required: ld_words=2, busy=0.
  - Fetch 0 returns 32'h00200713. Fetch 4 returns 32'h00A00413. Fetch 8 returns DEFAULT_INSTR with fault=0.
- **Partial final word:**
  - Stimulus: ld_start, then stream 33 75, with ld_last on the 2nd byte.
  - Required: ld_words=1. Fetch 0 returns 32'h00007533.
- **Faults:**
  - Fetch 0x2: instr=DEFAULT_INSTR, fault=1.
  - Fetch 4*DEPTH (0x100 when DEPTH=64): instr=DEFAULT_INSTR, fault=1.
  - Both results arrive one cycle after the request.
- **Overflow (DEPTH=4):**
  - Stimulus: stream 17 bytes, with ld_last on the 17th.
  - Required: ld_words=4, ld_overflow=1, FSM returns to IDLE.
  - A later ld_start clears ld_overflow and ld_words.
- **Busy and reset during load:**
  - While busy, fetch_en=1 gives instr_valid=0.
  - Assert rst_n=0 after 3 bytes. Required: ld_words=0, busy=0; fetch 0 returns DEFAULT_INSTR.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction memory with a byte-stream program loader.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no load running; fetches are served, loader bytes refused
//   LOAD  | bytes are assembled into words and committed from word 0 up
//
// Bytes are packed little-endian into an assembly register and written on
// the 4th byte or on ld_last. The write pointer doubles as ld_words: both
// advance on the same commit and are cleared together by ld_start.
// Fetches are blocked while busy, so the memory never sees a read and a
// write to the same word in one cycle.
module imem_loader #(
    parameter int             N             = 32,
    parameter int             DEPTH         = 64,
    parameter logic [N-1:0]   DEFAULT_INSTR = 32'h00000013
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N-1:0]             pc_out,
    input  logic                     fetch_en,
    output logic [N-1:0]             instr,
    output logic                     instr_valid,
    output logic                     fault,
    input  logic                     ld_start,
    input  logic                     ld_valid,
    input  logic [7:0]               ld_data,
    input  logic                     ld_last,
    output logic                     ld_ready,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   ld_words,
    output logic                     ld_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int WW = N - 2;
    localparam logic [AW:0]   DEPTH_P = (AW+1)'(DEPTH);
    localparam logic [WW-1:0] DEPTH_W = WW'(DEPTH);

    typedef enum logic {IDLE, LOAD} state_t;

    state_t         state_q;
    state_t         state_d;

    logic [1:0]     byte_cnt_q;
    logic [AW:0]    wptr_q;
    logic [N-1:0]   asm_q;
    logic [N-1:0]   asm_next;
    logic [N-1:0]   mem [DEPTH];

    logic           byte_acc;
    logic           full;
    logic           commit;

    logic           fetch_acc;
    logic [WW-1:0]  word_idx;
    logic           misaligned;
    logic           out_of_range;
    logic           unloaded;

    assign byte_acc = ld_valid && ld_ready && !ld_start;
    assign full     = (wptr_q == DEPTH_P);
    assign commit   = byte_acc && !full && ((byte_cnt_q == 2'd3) || ld_last);
    assign ld_words = wptr_q;

    assign fetch_acc    = fetch_en && !busy;
    assign word_idx     = pc_out[N-1:2];
    assign misaligned   = (pc_out[1:0] != 2'b00);
    assign out_of_range = (word_idx >= DEPTH_W);
    assign unloaded     = (word_idx >= WW'(wptr_q));

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: ld_start always (re)enters LOAD, ld_last on an accepted byte ends it
    always_comb begin
        state_d = state_q;
        if (ld_start) begin
            state_d = LOAD;
        end else if (state_q == LOAD && byte_acc && ld_last) begin
            state_d = IDLE;
        end
    end

    // FSM outputs
    always_comb begin
        ld_ready = 1'b0;
        busy     = 1'b0;
        if (state_q == LOAD) begin
            ld_ready = 1'b1;
            busy     = 1'b1;
        end
    end

    // Assembly: the first byte of a word clears the upper bytes so short final words are zero-filled
    always_comb begin
        asm_next = (byte_cnt_q == 2'd0) ? '0 : asm_q;
        asm_next[{byte_cnt_q, 3'b000} +: 8] = ld_data;
    end

    // Loader counters, assembly register and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_q  <= '0;
            wptr_q      <= '0;
            asm_q       <= '0;
            ld_overflow <= 1'b0;
        end else if (ld_start) begin
            byte_cnt_q  <= '0;
            wptr_q      <= '0;
            ld_overflow <= 1'b0;
        end else if (byte_acc) begin
            if (full) begin
                ld_overflow <= 1'b1;
            end else if (commit) begin
                byte_cnt_q <= '0;
                wptr_q     <= wptr_q + 1'b1;
            end else begin
                byte_cnt_q <= byte_cnt_q + 1'b1;
                asm_q      <= asm_next;
            end
        end
    end

    // Memory array write; contents are left unreset, ld_words gates every read
    always_ff @(posedge clk) begin
        if (commit) begin
            mem[wptr_q[AW-1:0]] <= asm_next;
        end
    end

    // Registered fetch port; instr and fault hold when no fetch is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr       <= DEFAULT_INSTR;
            instr_valid <= 1'b0;
            fault       <= 1'b0;
        end else begin
            instr_valid <= fetch_acc;
            if (fetch_acc) begin
                if (misaligned || out_of_range) begin
                    instr <= DEFAULT_INSTR;
                    fault <= 1'b1;
                end else if (unloaded) begin
                    instr <= DEFAULT_INSTR;
                    fault <= 1'b0;
                end else begin
                    instr <= mem[word_idx[AW-1:0]];
                    fault <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader (DEPTH=4): directed program loads with literal
// expectations, then randomized traffic checked every cycle against a
// byte-queue model of the loaded program.
module tb_imem_loader;

    localparam int          N     = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] DEF   = 32'h00000013;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [N-1:0]             pc_out = '0;
    logic                     fetch_en = 1'b0;
    logic [N-1:0]             instr;
    logic                     instr_valid;
    logic                     fault;
    logic                     ld_start = 1'b0;
    logic                     ld_valid = 1'b0;
    logic [7:0]               ld_data = '0;
    logic                     ld_last = 1'b0;
    logic                     ld_ready;
    logic                     busy;
    logic [$clog2(DEPTH):0]   ld_words;
    logic                     ld_overflow;

    int checks   = 0;
    int failures = 0;

    imem_loader #(.N(N), .DEPTH(DEPTH), .DEFAULT_INSTR(DEF)) dut (
        .clk(clk), .rst_n(rst_n), .pc_out(pc_out), .fetch_en(fetch_en),
        .instr(instr), .instr_valid(instr_valid), .fault(fault),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_last(ld_last), .ld_ready(ld_ready), .busy(busy),
        .ld_words(ld_words), .ld_overflow(ld_overflow)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [7:0]  bq[$];      // bytes of the current program actually stored
    bit          m_ended = 0;
    bit          m_busy  = 0;
    bit          m_ovf   = 0;
    logic [31:0] m_instr = DEF;
    bit          m_valid = 0;
    bit          m_fault = 0;
    int unsigned m_w;

    function automatic int words_loaded();
        int n = bq.size();
        int w = m_ended ? (n + 3) / 4 : n / 4;
        return (w > DEPTH) ? DEPTH : w;
    endfunction

    function automatic logic [31:0] word_at(int unsigned w);
        logic [31:0] r = '0;
        for (int k = 0; k < 4; k++)
            if (4 * w + k < bq.size()) r[8*k +: 8] = bq[4*w + k];
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bq.delete();
            m_ended = 0; m_busy = 0; m_ovf = 0;
            m_instr = DEF; m_valid = 0; m_fault = 0;
        end else begin
            if (fetch_en && !m_busy) begin
                m_valid = 1;
                m_w = pc_out >> 2;
                if ((pc_out % 4) != 0 || m_w >= DEPTH) begin
                    m_instr = DEF; m_fault = 1;
                end else if (m_w >= words_loaded()) begin
                    m_instr = DEF; m_fault = 0;
                end else begin
                    m_instr = word_at(m_w); m_fault = 0;
                end
            end else begin
                m_valid = 0;
            end
            if (ld_start) begin
                bq.delete();
                m_ended = 0; m_ovf = 0; m_busy = 1;
            end else if (m_busy && ld_valid) begin
                if (bq.size() >= 4 * DEPTH) m_ovf = 1;
                else bq.push_back(ld_data);
                if (ld_last) begin
                    m_ended = 1; m_busy = 0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        check("busy",        {31'b0, busy},        {31'b0, m_busy});
        check("ld_ready",    {31'b0, ld_ready},    {31'b0, m_busy});
        check("ld_words",    32'(ld_words),        32'(words_loaded()));
        check("ld_overflow", {31'b0, ld_overflow}, {31'b0, m_ovf});
        check("instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
        check("instr",       instr,                m_instr);
        check("fault",       {31'b0, fault},       {31'b0, m_fault});
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        ld_valid = 1'b1; ld_data = b; ld_last = last;
        tick();
        ld_valid = 1'b0; ld_last = 1'b0;
    endtask

    task automatic fetch(input string name, input logic [31:0] a,
                         input logic [31:0] exp_i, input logic exp_f);
        fetch_en = 1'b1; pc_out = a;
        tick();
        fetch_en = 1'b0;
        check({name, ".valid"}, {31'b0, instr_valid}, 32'd1);
        check({name, ".instr"}, instr, exp_i);
        check({name, ".fault"}, {31'b0, fault}, {31'b0, exp_f});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        logic [7:0] prog1 [8];
        prog1 = '{8'h13, 8'h07, 8'h20, 8'h00, 8'h13, 8'h04, 8'hA0, 8'h00};

        // Reset
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst.instr",    instr, 32'h00000013);
        check("rst.valid",    {31'b0, instr_valid}, 32'd0);
        check("rst.busy",     {31'b0, busy}, 32'd0);
        check("rst.ld_words", 32'(ld_words), 32'd0);
        fetch("rst.fetch0", 32'h0, 32'h00000013, 1'b0);

        // Two full words
        start_load();
        check("load1.busy", {31'b0, busy}, 32'd1);
        for (int i = 0; i < 8; i++) send_byte(prog1[i], i == 7);
        check("load1.ld_words", 32'(ld_words), 32'd2);
        check("load1.busy",     {31'b0, busy}, 32'd0);
        fetch("load1.f0", 32'h0, 32'h00200713, 1'b0);
        fetch("load1.f4", 32'h4, 32'h00A00413, 1'b0);
        fetch("load1.f8", 32'h8, DEF, 1'b0);

        // Partial final word
        start_load();
        send_byte(8'h33, 1'b0);
        send_byte(8'h75, 1'b1);
        check("load2.ld_words", 32'(ld_words), 32'd1);
        fetch("load2.f0", 32'h0, 32'h00007533, 1'b0);

        // Faults
        fetch("fault.mis",  32'h2, DEF, 1'b1);
        fetch("fault.oor",  32'(4 * DEPTH), DEF, 1'b1);

        // Overflow
        start_load();
        for (int i = 0; i < 17; i++) send_byte(8'(i + 1), i == 16);
        check("ovf.ld_words", 32'(ld_words), 32'd4);
        check("ovf.flag",     {31'b0, ld_overflow}, 32'd1);
        check("ovf.busy",     {31'b0, busy}, 32'd0);
        fetch("ovf.f12", 32'hC, 32'h100F0E0D, 1'b0);
        start_load();
        check("ovf.clr_flag",  {31'b0, ld_overflow}, 32'd0);
        check("ovf.clr_words", 32'(ld_words), 32'd0);
        send_byte(8'h01, 1'b1);

        // Fetch blocked while busy, then reset mid-load
        start_load();
        fetch_en = 1'b1; pc_out = '0;
        for (int i = 0; i < 3; i++) begin
            send_byte(8'hAA, 1'b0);
            check("busy.valid", {31'b0, instr_valid}, 32'd0);
        end
        fetch_en = 1'b0;
        rst_n = 1'b0;
        tick();
        check("rstld.ld_words", 32'(ld_words), 32'd0);
        check("rstld.busy",     {31'b0, busy}, 32'd0);
        rst_n = 1'b1;
        tick();
        fetch("rstld.f0", 32'h0, DEF, 1'b0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst_n    = ($urandom_range(0, 399) != 0);
            ld_start = m_busy ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 5) == 0);
            ld_valid = ($urandom_range(0, 3) != 0);
            ld_data  = 8'($urandom);
            ld_last  = ($urandom_range(0, 9) == 0);
            fetch_en = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) == 0) pc_out = 32'($urandom_range(0, 4 * DEPTH + 7));
            else                           pc_out = 32'($urandom_range(0, DEPTH)) << 2;
            tick();
        end
        rst_n = 1'b1; ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; fetch_en = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
